// File: rtl/apb_cmd_initiator.sv
// APB3 initiator: turns one command-stream beat into one SETUP/ACCESS transfer
// and returns read data, slave error and timeout status on a response stream.
module apb_cmd_initiator #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam int CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W:0] LIMIT = (CNT_W + 1)'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                state_q;
  logic                  psel_q;
  logic                  penable_q;
  logic                  pwrite_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic                  rsp_valid_q;
  logic                  rsp_err_q;
  logic                  rsp_timeout_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  timeout_hit;

  // Expiry is judged on the count this cycle would produce, so the limit
  // equals the number of ACCESS cycles spent before abort.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                       (({1'b0, cnt_q} + (CNT_W + 1)'(1)) == LIMIT);

  assign cmd_ready   = (state_q == IDLE) & ~PRESET;
  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign rsp_rdata   = rsp_rdata_q;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q       <= IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= '0;
      cnt_q         <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            paddr_q   <= cmd_addr;
            pwrite_q  <= cmd_write;
            pwdata_q  <= cmd_write ? cmd_wdata : '0;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            rsp_rdata_q   <= pwrite_q ? '0 : PRDATA;
            rsp_err_q     <= PSLVERR;
            rsp_timeout_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            state_q       <= RESP;
          end else if (timeout_hit) begin
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b1;
            rsp_valid_q   <= 1'b1;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            state_q       <= RESP;
          end else if (TIMEOUT_CYCLES != 0) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_cmd_initiator.sv
// Directed bench: stimulus pushes expected responses into a queue, a negedge
// monitor pops and compares them on every response handshake.
module tb_apb_cmd_initiator;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        PSEL, PENABLE, PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA, PRDATA;
  logic        PREADY, PSLVERR;

  apb_cmd_initiator #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
  } rsp_t;

  typedef struct packed {
    logic        w;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  waits;
    logic [31:0] prdata;
    logic        slverr;
    logic        stuck;
    logic [3:0]  hold;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_tmo;
  } vec_t;

  rsp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Response monitor
  always @(negedge PCLK) begin
    if (!PRESET && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_rsp: got rdata=%0h err=%0b tmo=%0b expected none",
                 rsp_rdata, rsp_err, rsp_timeout);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
        chk("rsp_err", 64'(rsp_err), 64'(e.err));
        chk("rsp_timeout", 64'(rsp_timeout), 64'(e.tmo));
        $display("rsp: rdata=%08h err=%0b tmo=%0b", rsp_rdata, rsp_err, rsp_timeout);
      end
    end
  end

  task automatic xfer(input vec_t v);
    int   acc_cycles;
    rsp_t e;
    acc_cycles = v.stuck ? 4 : int'(v.waits) + 1;
    if (v.hold != 0) rsp_ready = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = v.w;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    chk("psel_idle", 64'(PSEL), 64'd0);
    e.rdata = v.exp_rdata;
    e.err   = v.exp_err;
    e.tmo   = v.exp_tmo;
    exp_q.push_back(e);
    @(posedge PCLK); #1;
    cmd_valid = 1'b0;
    cmd_wdata = 32'h0;
    chk("setup_psel", 64'(PSEL), 64'd1);
    chk("setup_penable", 64'(PENABLE), 64'd0);
    chk("setup_paddr", 64'(PADDR), 64'(v.addr));
    chk("setup_pwrite", 64'(PWRITE), 64'(v.w));
    chk("setup_pwdata", 64'(PWDATA), v.w ? 64'(v.wdata) : 64'd0);
    @(posedge PCLK); #1;
    for (int i = 0; i < acc_cycles; i++) begin
      chk("access_psel", 64'(PSEL), 64'd1);
      chk("access_penable", 64'(PENABLE), 64'd1);
      chk("access_paddr", 64'(PADDR), 64'(v.addr));
      chk("access_pwdata", 64'(PWDATA), v.w ? 64'(v.wdata) : 64'd0);
      chk("access_rsp_valid", 64'(rsp_valid), 64'd0);
      PREADY  = !v.stuck && (i == int'(v.waits));
      PRDATA  = PREADY ? v.prdata : ~v.prdata;
      PSLVERR = PREADY ? v.slverr : 1'b1;
      @(posedge PCLK); #1;
    end
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    PRDATA  = 32'h0;
    chk("done_psel", 64'(PSEL), 64'd0);
    chk("done_penable", 64'(PENABLE), 64'd0);
    chk("done_rsp_valid", 64'(rsp_valid), 64'd1);
    if (v.hold != 0) begin
      cmd_valid = 1'b1;
      cmd_addr  = 8'hEE;
      for (int k = 0; k < int'(v.hold); k++) begin
        chk("hold_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("hold_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("hold_rsp_rdata", 64'(rsp_rdata), 64'(v.exp_rdata));
        chk("hold_rsp_err", 64'(rsp_err), 64'(v.exp_err));
        chk("hold_psel", 64'(PSEL), 64'd0);
        @(posedge PCLK); #1;
      end
      rsp_ready = 1'b1;
    end
    @(posedge PCLK); #1;
    cmd_valid = 1'b0;
    chk("after_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("after_cmd_ready", 64'(cmd_ready), 64'd1);
    $display("xfer: w=%0b addr=%02h wdata=%08h waits=%0d stuck=%0b hold=%0d",
             v.w, v.addr, v.wdata, v.waits, v.stuck, v.hold);
  endtask

  vec_t vecs[9];

  initial begin
    //            w     addr   wdata         waits prdata        slv   stuck hold  exp_rdata    err   tmo
    vecs[0] = '{1'b1, 8'h08, 32'hA5A5_0003, 4'd0, 32'hDEAD_BEEF, 1'b0, 1'b0, 4'd0, 32'h0,        1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'h80, 32'h1234_5678, 4'd3, 32'h0000_0002, 1'b0, 1'b0, 4'd0, 32'h2,        1'b0, 1'b0};
    vecs[2] = '{1'b0, 8'h44, 32'h0,         4'd1, 32'h0BAD_F00D, 1'b1, 1'b0, 4'd0, 32'h0BAD_F00D, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 8'h10, 32'h0000_0055, 4'd0, 32'h1111_1111, 1'b0, 1'b0, 4'd0, 32'h0,        1'b0, 1'b0};
    vecs[4] = '{1'b0, 8'h20, 32'h0,         4'd0, 32'h7777_7777, 1'b0, 1'b1, 4'd0, 32'h0,        1'b0, 1'b1};
    vecs[5] = '{1'b0, 8'h80, 32'h0,         4'd3, 32'h1357_9BDF, 1'b0, 1'b0, 4'd0, 32'h1357_9BDF, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 8'h3C, 32'hFFFF_0000, 4'd0, 32'hCAFE_0001, 1'b0, 1'b0, 4'd10, 32'hCAFE_0001, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 8'hFF, 32'hFFFF_FFFF, 4'd2, 32'h5555_5555, 1'b0, 1'b0, 4'd0, 32'h0,        1'b0, 1'b0};
    vecs[8] = '{1'b1, 8'h01, 32'h0000_0001, 4'd0, 32'h9999_9999, 1'b1, 1'b0, 4'd0, 32'h0,        1'b1, 1'b0};

    PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h0; cmd_wdata = 32'h0;
    rsp_ready = 1'b1; PRDATA = 32'h0; PREADY = 1'b0; PSLVERR = 1'b0;
    repeat (2) @(posedge PCLK);
    #1;
    chk("rst_psel", 64'(PSEL), 64'd0);
    chk("rst_penable", 64'(PENABLE), 64'd0);
    chk("rst_pwrite", 64'(PWRITE), 64'd0);
    chk("rst_paddr", 64'(PADDR), 64'd0);
    chk("rst_pwdata", 64'(PWDATA), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("rst_rsp_timeout", 64'(rsp_timeout), 64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    PRESET = 1'b0;
    #1;
    chk("rst_release_cmd_ready", 64'(cmd_ready), 64'd1);

    for (int i = 0; i < 9; i++) xfer(vecs[i]);

    // Reset while the slave is stalling in ACCESS: transfer vanishes silently.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h30;
    @(posedge PCLK); #1;
    cmd_valid = 1'b0;
    @(posedge PCLK); #1;
    chk("midrst_penable_pre", 64'(PENABLE), 64'd1);
    @(posedge PCLK); #1;
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    chk("midrst_psel", 64'(PSEL), 64'd0);
    chk("midrst_penable", 64'(PENABLE), 64'd0);
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_cmd_ready_in_rst", 64'(cmd_ready), 64'd0);
    PRESET = 1'b0;
    #1;
    chk("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
    for (int k = 0; k < 3; k++) begin
      @(posedge PCLK); #1;
      chk("midrst_no_rsp", 64'(rsp_valid), 64'd0);
    end

    xfer(vecs[1]);

    repeat (3) @(posedge PCLK);
    #1;
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion expected finish before 100000");
    $fatal(1);
  end

endmodule
